i2s_rx: RTL and testbench



---
 rtl/i2s_rx.sv | 237 +++++++++++++++++++++++
 tb/tb_i2s_rx.sv | 445 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2s_rx.sv
// ----------------------------------------------------------------------------
// i2s_rx
//
// I2S receiver front end for the 24-bit FIR stage. The serial link (SCK, WS,
// SD) is asynchronous to clk and is oversampled: every input is passed
// through a two-flop synchroniser, and a rising SCK edge is detected in the
// clk domain. The receiver then finds slot boundaries from WS and assembles
// each slot MSB-first into a DATA_W-bit word. Once a stereo frame is complete,
// it is presented as a signed left/right pair with a one-cycle valid strobe.
//
// Parameters
//   DATA_W    sample width delivered (MSB-first, left-justified in the slot)
//   SLOT_MAX  longest legal slot in SCK bits; longer slots flag an error
//
// Ports
//   clk       system clock, at least 4x the SCK frequency
//   reset_n   asynchronous active-low reset
//   i2s_sck   I2S bit clock (asynchronous)
//   i2s_ws    I2S word select, 0 = left, 1 = right (asynchronous)
//   i2s_sd    I2S serial data (asynchronous)
//   data_l    signed left sample of the last complete frame
//   data_r    signed right sample of the last complete frame
//   valid     one-cycle pulse when data_l/data_r have just been updated
//   slot_err  one-cycle pulse when a slot ends with fewer than DATA_W or
//             more than SLOT_MAX bits
//   locked    high while the frame aligner is in RUN
// ----------------------------------------------------------------------------
module i2s_rx #(
    parameter int DATA_W   = 24,
    parameter int SLOT_MAX = 32
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     i2s_sck,
    input  logic                     i2s_ws,
    input  logic                     i2s_sd,
    output logic signed [DATA_W-1:0] data_l,
    output logic signed [DATA_W-1:0] data_r,
    output logic                     valid,
    output logic                     slot_err,
    output logic                     locked
);

    // The bit counter has to hold SLOT_MAX+1, which is its saturation value.
    localparam int CNT_W = $clog2(SLOT_MAX + 2);
    // The slot length is bit_cnt + 1, so it needs one bit more.
    localparam int LEN_W = CNT_W + 1;

    localparam logic [CNT_W-1:0] CNT_SAT = CNT_W'(SLOT_MAX + 1);
    localparam logic [LEN_W-1:0] LEN_MIN = LEN_W'(DATA_W);
    localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(SLOT_MAX);

    typedef enum logic {
        ST_ALIGN = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

    // ------------------------------------------------------------------
    // Synchronisers
    //   sck_sync_reg[1] is the synchronised SCK.
    //   sck_sync_reg[2] is its previous value, used for edge detection.
    //   WS and SD are taken from the same stage ([1]) as SCK, so they
    //   stay aligned with the detected edge.
    // ------------------------------------------------------------------
    logic [2:0] sck_sync_reg;
    logic [1:0] ws_sync_reg;
    logic [1:0] sd_sync_reg;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sck_sync_reg <= '0;
            ws_sync_reg  <= '0;
            sd_sync_reg  <= '0;
        end else begin
            sck_sync_reg <= {sck_sync_reg[1:0], i2s_sck};
            ws_sync_reg  <= {ws_sync_reg[0], i2s_ws};
            sd_sync_reg  <= {sd_sync_reg[0], i2s_sd};
        end
    end

    logic bit_event;
    logic ws_now;
    logic sd_now;

    assign bit_event = sck_sync_reg[1] & ~sck_sync_reg[2];
    assign ws_now    = ws_sync_reg[1];
    assign sd_now    = sd_sync_reg[1];

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    state_t              state_reg,     state_next;
    logic                ws_prev_reg,   ws_prev_next;
    logic [CNT_W-1:0]    bit_cnt_reg,   bit_cnt_next;
    logic [DATA_W-1:0]   sr_reg,        sr_next;
    logic [DATA_W-1:0]   left_hold_reg, left_hold_next;
    logic [DATA_W-1:0]   data_l_reg,    data_l_next;
    logic [DATA_W-1:0]   data_r_reg,    data_r_next;
    logic                valid_reg,     valid_next;
    logic                slot_err_reg,  slot_err_next;
    logic                locked_reg,    locked_next;
    // synced_reg is set once the first slot boundary after reset has been
    // seen. The slot that was in progress when reset was released is
    // partial by nature, so its length is not reported as an error.
    logic                synced_reg,    synced_next;

    // ------------------------------------------------------------------
    // Bit insertion
    // bit_sel is a one-hot decode of the current bit position within the
    // sample. It is all-zero once bit_cnt reaches DATA_W, so trailing slot
    // bits fall through without changing the word.
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] bit_sel;
    logic [DATA_W-1:0] word;

    for (genvar gi = 0; gi < DATA_W; gi++) begin : g_bit_sel
        assign bit_sel[gi] = (bit_cnt_reg == CNT_W'(DATA_W - 1 - gi));
    end

    // word is the shift register with this edge's bit already merged in.
    // At a slot end it is the complete received word.
    assign word = (sr_reg & ~bit_sel) | (bit_sel & {DATA_W{sd_now}});

    // ------------------------------------------------------------------
    // Slot boundary and length check
    // The bit on the edge where WS changes is the LSB of the slot that
    // is ending, so that bit is counted in the slot length.
    // ------------------------------------------------------------------
    logic             slot_end;
    logic [LEN_W-1:0] slot_len;
    logic             len_bad;

    assign slot_end = bit_event && (ws_now != ws_prev_reg);
    assign slot_len = {1'b0, bit_cnt_reg} + LEN_W'(1);
    assign len_bad  = (slot_len < LEN_MIN) || (slot_len > LEN_MAX);

    // ------------------------------------------------------------------
    // Next-state / datapath logic
    // ------------------------------------------------------------------
    always_comb begin
        state_next     = state_reg;
        ws_prev_next   = ws_prev_reg;
        bit_cnt_next   = bit_cnt_reg;
        sr_next        = sr_reg;
        left_hold_next = left_hold_reg;
        data_l_next    = data_l_reg;
        data_r_next    = data_r_reg;
        synced_next    = synced_reg;
        valid_next     = 1'b0;
        slot_err_next  = 1'b0;

        if (slot_end) begin
            // Close the slot and start the next one from a cleared word.
            sr_next       = '0;
            bit_cnt_next  = '0;
            ws_prev_next  = ws_now;
            synced_next   = 1'b1;
            slot_err_next = synced_reg && len_bad;

            case (state_reg)
                ST_ALIGN: begin
                    // WS falling to 0 marks the start of a left slot.
                    // That is the first point where a whole frame can be
                    // collected. Anything received before that is dropped.
                    if (!ws_now) begin
                        state_next = ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (!ws_prev_reg) begin
                        left_hold_next = word;
                    end else begin
                        data_l_next = left_hold_reg;
                        data_r_next = word;
                        valid_next  = 1'b1;
                    end
                    // A bad slot length means framing can no longer be
                    // trusted. The current frame is still delivered, and
                    // then the receiver re-aligns.
                    if (len_bad) begin
                        state_next = ST_ALIGN;
                    end
                end
                default: begin
                    state_next = ST_ALIGN;
                end
            endcase
        end else if (bit_event) begin
            sr_next = word;
            // The counter saturates at SLOT_MAX+1. This is enough to flag
            // an over-long slot without the counter wrapping.
            if (bit_cnt_reg != CNT_SAT) begin
                bit_cnt_next = bit_cnt_reg + CNT_W'(1);
            end
        end

        locked_next = (state_next == ST_RUN);
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg     <= ST_ALIGN;
            ws_prev_reg   <= 1'b0;
            bit_cnt_reg   <= '0;
            sr_reg        <= '0;
            left_hold_reg <= '0;
            data_l_reg    <= '0;
            data_r_reg    <= '0;
            valid_reg     <= 1'b0;
            slot_err_reg  <= 1'b0;
            locked_reg    <= 1'b0;
            synced_reg    <= 1'b0;
        end else begin
            state_reg     <= state_next;
            ws_prev_reg   <= ws_prev_next;
            bit_cnt_reg   <= bit_cnt_next;
            sr_reg        <= sr_next;
            left_hold_reg <= left_hold_next;
            data_l_reg    <= data_l_next;
            data_r_reg    <= data_r_next;
            valid_reg     <= valid_next;
            slot_err_reg  <= slot_err_next;
            locked_reg    <= locked_next;
            synced_reg    <= synced_next;
        end
    end

    assign data_l   = data_l_reg;
    assign data_r   = data_r_reg;
    assign valid    = valid_reg;
    assign slot_err = slot_err_reg;
    assign locked   = locked_reg;

endmodule

// File: tb/tb_i2s_rx.sv
// ----------------------------------------------------------------------------
// tb_i2s_rx
//
// Directed testbench for i2s_rx. A bit-level driver produces I2S frames, and
// WS changes on the last bit of each slot. A monitor logs every valid pair
// and counts slot_err pulses. Each test task compares what was captured
// against hand-computed expected values.
// ----------------------------------------------------------------------------
module tb_i2s_rx;

    logic               clk      = 1'b0;
    logic               reset_n  = 1'b0;
    logic               i2s_sck  = 1'b1;
    logic               i2s_ws   = 1'b0;
    logic               i2s_sd   = 1'b0;
    logic signed [23:0] data_l;
    logic signed [23:0] data_r;
    logic               valid;
    logic               slot_err;
    logic               locked;

    int tests_run    = 0;
    int tests_failed = 0;
    int half_ns      = 40;

    logic signed [23:0] cap_l[$];
    logic signed [23:0] cap_r[$];
    int                 err_cnt = 0;

    i2s_rx #(
        .DATA_W  (24),
        .SLOT_MAX(32)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .i2s_sck (i2s_sck),
        .i2s_ws  (i2s_ws),
        .i2s_sd  (i2s_sd),
        .data_l  (data_l),
        .data_r  (data_r),
        .valid   (valid),
        .slot_err(slot_err),
        .locked  (locked)
    );

    // Rising edges are at 5, 15, 25, ...
    // The stimulus always changes on multiples of 10, which are falling edges.
    always #5 clk = ~clk;

    // Monitor: one line per received frame.
    always @(negedge clk) begin
        if (valid) begin
            cap_l.push_back(data_l);
            cap_r.push_back(data_r);
            $display("[TB] frame %0d: data_l=%h data_r=%h", cap_l.size(), data_l, data_r);
        end
        if (slot_err) begin
            err_cnt++;
            $display("[TB] slot_err pulse %0d", err_cnt);
        end
    end

    // Place a 24-bit sample left-justified in a 32-bit slot.
    function automatic logic [63:0] j32(input logic [23:0] s);
        return {32'd0, s, 8'd0};
    endfunction

    // Drive bits [from, upto) of a slot of length len.
    // Bit i of the slot is d[len-1-i].
    // WS takes the next channel's value on the slot's last bit.
    task automatic send_bits(input logic ch, input logic nxt, input logic [63:0] d,
                             input int len, input int from, input int upto);
        for (int i = from; i < upto; i++) begin
            i2s_sck = 1'b0;
            i2s_ws  = (i == len - 1) ? nxt : ch;
            i2s_sd  = d[len-1-i];
            #(half_ns);
            i2s_sck = 1'b1;
            #(half_ns);
        end
    endtask

    task automatic send_frame(input logic [63:0] l, input int ll,
                              input logic [63:0] r, input int rl);
        send_bits(1'b0, 1'b1, l, ll, 0, ll);
        send_bits(1'b1, 1'b0, r, rl, 0, rl);
    endtask

    task automatic settle();
        #200;
    endtask

    // ------------------------------------------------------------------
    task automatic test_reset();
        // reset_n is low from time 0. Toggle SCK through a whole frame.
        send_frame(j32(24'h123456), 32, j32(24'hABCDEF), 32);
        settle();
        tests_run++;
        if (data_l !== 24'd0) begin
            tests_failed++;
            $display("FAIL reset_data_l: got %h expected 000000", data_l);
        end
        tests_run++;
        if (data_r !== 24'd0) begin
            tests_failed++;
            $display("FAIL reset_data_r: got %h expected 000000", data_r);
        end
        tests_run++;
        if (valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_valid: got %b expected 0", valid);
        end
        tests_run++;
        if (slot_err !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_slot_err: got %b expected 0", slot_err);
        end
        tests_run++;
        if (locked !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_locked: got %b expected 0", locked);
        end
        tests_run++;
        if (cap_l.size() !== 0) begin
            tests_failed++;
            $display("FAIL reset_no_valid: got %0d frames expected 0", cap_l.size());
        end
        // Release reset with SCK low so that no edge is detected spuriously.
        i2s_sck = 1'b0;
        #20;
        reset_n = 1'b1;
        #20;
    endtask

    // ------------------------------------------------------------------
    task automatic test_basic();
        int base;
        int ebase;
        base  = cap_l.size();
        ebase = err_cnt;
        // Alignment frame: the left slot ends with WS rising, so the
        // receiver stays in ALIGN.
        send_bits(1'b0, 1'b1, j32(24'h123456), 32, 0, 32);
        settle();
        tests_run++;
        if (locked !== 1'b0) begin
            tests_failed++;
            $display("FAIL basic_locked_align: got %b expected 0", locked);
        end
        send_bits(1'b1, 1'b0, j32(24'hABCDEF), 32, 0, 32);
        settle();
        tests_run++;
        if (locked !== 1'b1) begin
            tests_failed++;
            $display("FAIL basic_locked_run: got %b expected 1", locked);
        end
        for (int f = 0; f < 3; f++) begin
            send_frame(j32(24'h123456), 32, j32(24'hABCDEF), 32);
        end
        settle();
        tests_run++;
        if (cap_l.size() - base !== 3) begin
            tests_failed++;
            $display("FAIL basic_valid_count: got %0d expected 3", cap_l.size() - base);
        end
        for (int k = 0; k < 3; k++) begin
            tests_run++;
            if (base + k >= cap_l.size()) begin
                tests_failed++;
                $display("FAIL basic_frame%0d: got no frame expected 123456/abcdef", k);
            end else if (cap_l[base+k] !== 24'h123456 || cap_r[base+k] !== 24'hABCDEF) begin
                tests_failed++;
                $display("FAIL basic_frame%0d: got %h/%h expected 123456/abcdef",
                         k, cap_l[base+k], cap_r[base+k]);
            end
        end
        tests_run++;
        if (err_cnt - ebase !== 0) begin
            tests_failed++;
            $display("FAIL basic_no_err: got %0d errors expected 0", err_cnt - ebase);
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_signed();
        int base;
        int ebase;
        int vl;
        int vr;
        base  = cap_l.size();
        ebase = err_cnt;
        for (int f = 0; f < 2; f++) begin
            send_frame({40'd0, 24'h800000}, 24, {40'd0, 24'h7FFFFF}, 24);
        end
        settle();
        tests_run++;
        if (cap_l.size() - base !== 2) begin
            tests_failed++;
            $display("FAIL signed_valid_count: got %0d expected 2", cap_l.size() - base);
        end
        for (int k = 0; k < 2; k++) begin
            tests_run++;
            if (base + k >= cap_l.size()) begin
                tests_failed++;
                $display("FAIL signed_frame%0d: got no frame expected -8388608/8388607", k);
            end else begin
                vl = cap_l[base+k];
                vr = cap_r[base+k];
                if (vl != -8388608 || vr != 8388607) begin
                    tests_failed++;
                    $display("FAIL signed_frame%0d: got %0d/%0d expected -8388608/8388607",
                             k, vl, vr);
                end
            end
        end
        tests_run++;
        if (err_cnt - ebase !== 0) begin
            tests_failed++;
            $display("FAIL signed_no_err: got %0d errors expected 0", err_cnt - ebase);
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_short();
        int base;
        int ebase;
        base  = cap_l.size();
        ebase = err_cnt;
        // Short right slot: the frame is still delivered, zero-padded.
        send_frame(j32(24'h111111), 32, {48'd0, 16'hBEEF}, 16);
        settle();
        tests_run++;
        if (base >= cap_l.size()) begin
            tests_failed++;
            $display("FAIL short_frame: got no frame expected 111111/beef00");
        end else if (cap_l[base] !== 24'h111111 || cap_r[base] !== 24'hBEEF00) begin
            tests_failed++;
            $display("FAIL short_frame: got %h/%h expected 111111/beef00", cap_l[base], cap_r[base]);
        end
        tests_run++;
        if (err_cnt - ebase !== 1) begin
            tests_failed++;
            $display("FAIL short_err_once: got %0d errors expected 1", err_cnt - ebase);
        end
        tests_run++;
        if (locked !== 1'b0) begin
            tests_failed++;
            $display("FAIL short_unlocked: got %b expected 0", locked);
        end
        // All slots are 16 bits: every slot end flags an error and no frame
        // is delivered. 3 frames plus one extra left slot give 7 slot ends.
        for (int f = 0; f < 3; f++) begin
            send_frame({48'd0, 16'hBEEF}, 16, {48'd0, 16'hCAFE}, 16);
        end
        send_bits(1'b0, 1'b1, {48'd0, 16'hBEEF}, 16, 0, 16);
        settle();
        tests_run++;
        if (err_cnt - ebase !== 8) begin
            tests_failed++;
            $display("FAIL short_err_every_slot: got %0d errors expected 8", err_cnt - ebase);
        end
        tests_run++;
        if (cap_l.size() - base !== 1) begin
            tests_failed++;
            $display("FAIL short_no_valid: got %0d frames expected 1", cap_l.size() - base);
        end
        tests_run++;
        if (locked !== 1'b0) begin
            tests_failed++;
            $display("FAIL short_locked_low: got %b expected 0", locked);
        end
        // A good right slot realigns: its end starts a left slot.
        send_bits(1'b1, 1'b0, j32(24'h000001), 32, 0, 32);
        settle();
        tests_run++;
        if (locked !== 1'b1) begin
            tests_failed++;
            $display("FAIL short_relock: got %b expected 1", locked);
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_long();
        int base;
        int ebase;
        logic [23:0] exp_l[3];
        logic [23:0] exp_r[3];
        base  = cap_l.size();
        ebase = err_cnt;
        exp_l[0] = 24'h0A0B0C; exp_r[0] = 24'h0D0E0F;
        exp_l[1] = 24'h112233; exp_r[1] = 24'h445566;
        exp_l[2] = 24'h999999; exp_r[2] = 24'hAAAAAA;
        send_frame(j32(24'h0A0B0C), 32, j32(24'h0D0E0F), 32);
        // 40-bit right slot whose trailing bits are ones, to be ignored.
        send_frame(j32(24'h112233), 32, {24'd0, 24'h445566, 16'hFFFF}, 40);
        settle();
        tests_run++;
        if (err_cnt - ebase !== 1) begin
            tests_failed++;
            $display("FAIL long_err_once: got %0d errors expected 1", err_cnt - ebase);
        end
        tests_run++;
        if (locked !== 1'b0) begin
            tests_failed++;
            $display("FAIL long_unlocked: got %b expected 0", locked);
        end
        // This frame is used only for realignment.
        send_frame(j32(24'h777777), 32, j32(24'h888888), 32);
        settle();
        tests_run++;
        if (cap_l.size() - base !== 2) begin
            tests_failed++;
            $display("FAIL long_realign_no_valid: got %0d frames expected 2", cap_l.size() - base);
        end
        send_frame(j32(24'h999999), 32, j32(24'hAAAAAA), 32);
        settle();
        tests_run++;
        if (cap_l.size() - base !== 3) begin
            tests_failed++;
            $display("FAIL long_valid_count: got %0d frames expected 3", cap_l.size() - base);
        end
        for (int k = 0; k < 3; k++) begin
            tests_run++;
            if (base + k >= cap_l.size()) begin
                tests_failed++;
                $display("FAIL long_frame%0d: got no frame expected %h/%h", k, exp_l[k], exp_r[k]);
            end else if (cap_l[base+k] !== exp_l[k] || cap_r[base+k] !== exp_r[k]) begin
                tests_failed++;
                $display("FAIL long_frame%0d: got %h/%h expected %h/%h",
                         k, cap_l[base+k], cap_r[base+k], exp_l[k], exp_r[k]);
            end
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_reset_mid();
        int base;
        base = cap_l.size();
        send_bits(1'b0, 1'b1, j32(24'hFFFFFF), 32, 0, 10);
        #30;
        reset_n = 1'b0;
        #1;
        tests_run++;
        if (data_l !== 24'd0 || data_r !== 24'd0) begin
            tests_failed++;
            $display("FAIL midreset_data: got %h/%h expected 000000/000000", data_l, data_r);
        end
        tests_run++;
        if (locked !== 1'b0) begin
            tests_failed++;
            $display("FAIL midreset_locked: got %b expected 0", locked);
        end
        #9;
        i2s_sck = 1'b0;
        #20;
        reset_n = 1'b1;
        #20;
        // Finish the interrupted left slot, then send its right slot.
        // Neither slot may be delivered.
        send_bits(1'b0, 1'b1, j32(24'hFFFFFF), 32, 10, 32);
        send_bits(1'b1, 1'b0, j32(24'hEEEEEE), 32, 0, 32);
        send_frame(j32(24'h135790), 32, j32(24'h2468AC), 32);
        send_frame(j32(24'hFEDCBA), 32, j32(24'h012345), 32);
        settle();
        tests_run++;
        if (cap_l.size() - base !== 2) begin
            tests_failed++;
            $display("FAIL midreset_valid_count: got %0d frames expected 2", cap_l.size() - base);
        end
        tests_run++;
        if (base >= cap_l.size()) begin
            tests_failed++;
            $display("FAIL midreset_first: got no frame expected 135790/2468ac");
        end else if (cap_l[base] !== 24'h135790 || cap_r[base] !== 24'h2468AC) begin
            tests_failed++;
            $display("FAIL midreset_first: got %h/%h expected 135790/2468ac", cap_l[base], cap_r[base]);
        end
        tests_run++;
        if (base + 1 >= cap_l.size()) begin
            tests_failed++;
            $display("FAIL midreset_second: got no frame expected fedcba/012345");
        end else if (cap_l[base+1] !== 24'hFEDCBA || cap_r[base+1] !== 24'h012345) begin
            tests_failed++;
            $display("FAIL midreset_second: got %h/%h expected fedcba/012345",
                     cap_l[base+1], cap_r[base+1]);
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_back_to_back();
        int base;
        int ebase;
        logic [23:0] exp_l[100];
        logic [23:0] exp_r[100];
        half_ns = 20;
        i2s_sck = 1'b0;
        reset_n = 1'b0;
        #20;
        reset_n = 1'b1;
        #20;
        base  = cap_l.size();
        ebase = err_cnt;
        for (int f = 0; f < 100; f++) begin
            exp_l[f] = 24'($urandom);
            exp_r[f] = 24'($urandom);
            send_frame(j32(exp_l[f]), 32, j32(exp_r[f]), 32);
        end
        settle();
        tests_run++;
        if (cap_l.size() - base !== 99) begin
            tests_failed++;
            $display("FAIL fast_valid_count: got %0d frames expected 99", cap_l.size() - base);
        end
        tests_run++;
        if (err_cnt - ebase !== 0) begin
            tests_failed++;
            $display("FAIL fast_no_err: got %0d errors expected 0", err_cnt - ebase);
        end
        for (int k = 0; k < 99; k++) begin
            tests_run++;
            if (base + k >= cap_l.size()) begin
                tests_failed++;
                $display("FAIL fast_frame%0d: got no frame expected %h/%h",
                         k + 1, exp_l[k+1], exp_r[k+1]);
            end else if (cap_l[base+k] !== exp_l[k+1] || cap_r[base+k] !== exp_r[k+1]) begin
                tests_failed++;
                $display("FAIL fast_frame%0d: got %h/%h expected %h/%h",
                         k + 1, cap_l[base+k], cap_r[base+k], exp_l[k+1], exp_r[k+1]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_signed();
        test_short();
        test_long();
        test_reset_mid();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
